// File: rtl/genius_seq_player.sv
// Genius sequence playback controller: stores up to 16 colour indices and
// replays them as lit/dark steps driving the colour mux select and LED enable.
module genius_seq_player #(
   parameter int MAX_LEN = 16,
   parameter int ON_CYC  = 4,
   parameter int OFF_CYC = 2
) (
   input  logic       CLK_i,
   input  logic       RST_N_i,
   input  logic       WR_EN_i,
   input  logic [3:0] WR_ADDR_i,
   input  logic [1:0] WR_DATA_i,
   input  logic [4:0] LEN_i,
   input  logic       START_i,
   input  logic       ABORT_i,
   output logic [1:0] SEL_o,
   output logic       LED_EN_o,
   output logic       BUSY_o,
   output logic       DONE_o
);

   localparam int CMAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
   localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t        state;
   logic [4:0]    len_r;
   logic [3:0]    idx_r;
   logic [CW-1:0] cnt_r;
   logic [1:0]    mem [MAX_LEN];

   logic [4:0] len_clamped;
   logic       last_step;
   logic [3:0] idx_next;

   assign len_clamped = (LEN_i > LEN_MAX) ? LEN_MAX : LEN_i;
   assign last_step   = ({1'b0, idx_r} == (len_r - 5'd1));
   assign idx_next    = idx_r + 4'd1;

   // Sequence memory; writes land in any state, playback only samples it
   // when a step is entered, so rewriting the lit step never glitches SEL_o.
   always_ff @(posedge CLK_i or negedge RST_N_i) begin
      if (!RST_N_i) begin
         for (int i = 0; i < MAX_LEN; i++) mem[i] <= 2'd0;
      end else if (WR_EN_i) begin
         mem[WR_ADDR_i] <= WR_DATA_i;
      end
   end

   always_ff @(posedge CLK_i or negedge RST_N_i) begin
      if (!RST_N_i) begin
         state    <= IDLE;
         len_r    <= 5'd0;
         idx_r    <= 4'd0;
         cnt_r    <= '0;
         SEL_o    <= 2'd0;
         LED_EN_o <= 1'b0;
         BUSY_o   <= 1'b0;
         DONE_o   <= 1'b0;
      end else begin
         DONE_o <= 1'b0;
         if (ABORT_i) begin
            // Abort outranks everything, including a simultaneous start in IDLE.
            if (state != IDLE) begin
               state    <= IDLE;
               LED_EN_o <= 1'b0;
               BUSY_o   <= 1'b0;
               cnt_r    <= '0;
               idx_r    <= 4'd0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (START_i) begin
                     if (LEN_i == 5'd0) begin
                        DONE_o <= 1'b1;
                     end else begin
                        len_r    <= len_clamped;
                        idx_r    <= 4'd0;
                        SEL_o    <= mem[0];
                        LED_EN_o <= 1'b1;
                        BUSY_o   <= 1'b1;
                        cnt_r    <= '0;
                        state    <= ON;
                     end
                  end
               end
               ON: begin
                  if (cnt_r == ON_LAST) begin
                     LED_EN_o <= 1'b0;
                     cnt_r    <= '0;
                     state    <= OFF;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
               OFF: begin
                  if (cnt_r == OFF_LAST) begin
                     cnt_r <= '0;
                     if (last_step) begin
                        state  <= IDLE;
                        BUSY_o <= 1'b0;
                        DONE_o <= 1'b1;
                     end else begin
                        idx_r    <= idx_next;
                        SEL_o    <= mem[idx_next];
                        LED_EN_o <= 1'b1;
                        state    <= ON;
                     end
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
